// File: rtl/noisy_sine_source_pkg.sv
// Shared constants for the noisy sine source: sample format, the 32-entry
// offset-binary sine table and the LFSR seed/mask.
package noisy_sine_source_pkg;

  localparam int N     = 16;
  localparam int DEPTH = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // round(32768 + 16384*sin(2*pi*k/32)), unsigned offset binary
  localparam logic [15:0] SINE [DEPTH] = '{
    16'h8000, 16'h8C7C, 16'h987E, 16'hA38E, 16'hAD41, 16'hB537, 16'hBB21, 16'hBEC5,
    16'hC000, 16'hBEC5, 16'hBB21, 16'hB537, 16'hAD41, 16'hA38E, 16'h987E, 16'h8C7C,
    16'h8000, 16'h7384, 16'h6782, 16'h5C72, 16'h52BF, 16'h4AC9, 16'h44DF, 16'h413B,
    16'h4000, 16'h413B, 16'h44DF, 16'h4AC9, 16'h52BF, 16'h5C72, 16'h6782, 16'h7384
  };

  // What the control logic does on a given enabled/disabled cycle.
  typedef enum logic [1:0] {
    CYC_HOLD   = 2'd0,
    CYC_COUNT  = 2'd1,
    CYC_SAMPLE = 2'd2
  } cycle_kind_e;

  // Clamp an 18-bit signed sum into the unsigned 16-bit sample range.
  function automatic logic [15:0] sat18(input logic signed [17:0] s);
    logic [15:0] r;
    if (s[17])      r = 16'h0000;
    else if (s[16]) r = 16'hFFFF;
    else            r = s[15:0];
    return r;
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle with step=1.
// The seed is non-zero and the mask is maximal-length, so zero is unreachable.
module lfsr16_galois (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  output logic [15:0] state
);
  import noisy_sine_source_pkg::*;

  logic [15:0] state_next;

  always_comb begin
    state_next = {1'b0, state[15:1]};
    if (state[0]) state_next = state_next ^ LFSR_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  state <= LFSR_SEED;
    else if (step) state <= state_next;
  end

endmodule

// File: rtl/noisy_sine_source.sv
// Sine table walker with rate divider and saturating LFSR noise injection.
// One sample per (rate_div+1) enabled cycles; output registered with its strobe.
module noisy_sine_source #(
  parameter int N     = 16,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [7:0]   rate_div,
  input  logic [4:0]   noise_shift,
  output logic [N-1:0] noisy,
  output logic         sample_valid,
  output logic         wrap
);
  import noisy_sine_source_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      addr;
  logic [7:0]         cnt;
  logic [15:0]        lfsr_state;
  cycle_kind_e        cycle_kind;
  logic               lfsr_step;
  logic signed [15:0] lfsr_signed;
  logic signed [15:0] noise;
  logic signed [17:0] sum;
  logic [15:0]        sine_val;
  logic [15:0]        sample_next;

  // Lowering rate_div below cnt samples at once thanks to >=.
  always_comb begin
    cycle_kind = CYC_HOLD;
    if (enable) begin
      if (cnt >= rate_div) cycle_kind = CYC_SAMPLE;
      else                 cycle_kind = CYC_COUNT;
    end
  end

  assign lfsr_step = (cycle_kind == CYC_SAMPLE);

  lfsr16_galois u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step),
    .state   (lfsr_state)
  );

  // Noise uses the LFSR value before this sample's step.
  always_comb begin
    lfsr_signed = lfsr_state;
    noise       = 16'sd0;
    if (!noise_shift[4]) noise = lfsr_signed >>> noise_shift[3:0];
  end

  always_comb begin
    sine_val    = SINE[addr];
    sum         = $signed({2'b00, sine_val}) + $signed({{2{noise[15]}}, noise});
    sample_next = sat18(sum);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr         <= '0;
      cnt          <= '0;
      noisy        <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
      case (cycle_kind)
        CYC_SAMPLE: begin
          cnt          <= '0;
          noisy        <= N'(sample_next);
          sample_valid <= 1'b1;
          wrap         <= (addr == AW'(DEPTH - 1));
          addr         <= addr + 1'b1;
        end
        CYC_COUNT: cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noisy_sine_source.sv
// Randomized and directed bench for noisy_sine_source against a
// per-cycle behavioural model derived from the sample/count/hold rules.
module tb_noisy_sine_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  rate_div;
  logic [4:0]  noise_shift;
  logic [15:0] noisy;
  logic        sample_valid;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  int sine_ref [32];
  int m_cnt, m_addr, m_lfsr, m_noisy, m_valid, m_wrap;

  always #5 clk = ~clk;

  noisy_sine_source #(.N(16), .DEPTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .rate_div     (rate_div),
    .noise_shift  (noise_shift),
    .noisy        (noisy),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lfsr_next(input int s);
    int r;
    r = s >> 1;
    if (s & 1) r = r ^ 'hB400;
    return r;
  endfunction

  function automatic int noise_ref(input int s, input int sh);
    int v;
    v = s;
    if (v >= 32768) v = v - 65536;
    if (sh >= 16) return 0;
    return v >>> sh;
  endfunction

  function automatic int sat_ref(input int x);
    if (x < 0) return 0;
    if (x > 65535) return 65535;
    return x;
  endfunction

  task automatic model_step();
    if (!reset_n) begin
      m_cnt = 0; m_addr = 0; m_lfsr = 'hACE1;
      m_noisy = 0; m_valid = 0; m_wrap = 0;
    end else if (enable && m_cnt >= int'(rate_div)) begin
      m_noisy = sat_ref(sine_ref[m_addr] + noise_ref(m_lfsr, int'(noise_shift)));
      m_valid = 1;
      m_wrap  = (m_addr == 31) ? 1 : 0;
      m_addr  = (m_addr + 1) % 32;
      m_lfsr  = lfsr_next(m_lfsr);
      m_cnt   = 0;
    end else begin
      if (enable) m_cnt++;
      m_valid = 0;
      m_wrap  = 0;
    end
  endtask

  // Inputs are set between edges; outputs are sampled 1 time unit after the edge.
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_eq("sample_valid", {31'd0, sample_valid}, m_valid);
    check_eq("wrap", {31'd0, wrap}, m_wrap);
    check_eq("noisy", {16'd0, noisy}, m_noisy);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) run_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    real pi;
    int hi_seen, lo_seen, gap, last, guard, l, exp_v;
    pi = 3.14159265358979;
    for (int k = 0; k < 32; k++)
      sine_ref[k] = $rtoi(32768.0 + 16384.0 * $sin(2.0 * pi * k / 32.0) + 0.5);
    m_cnt = 0; m_addr = 0; m_lfsr = 'hACE1; m_noisy = 0; m_valid = 0; m_wrap = 0;

    reset_n = 1'b0; enable = 1'b1; rate_div = 8'd0; noise_shift = 5'd16;

    // reset overrides enable
    do_reset(3);
    check_eq("rst_noisy", {16'd0, noisy}, 0);
    check_eq("rst_valid", {31'd0, sample_valid}, 0);

    // clean sweep: 33 samples, back-to-back
    for (int i = 0; i < 33; i++) begin
      run_cycle();
      check_eq("sweep_val", {16'd0, noisy}, sine_ref[i % 32]);
      check_eq("sweep_wrap", {31'd0, wrap}, ((i % 32) == 31) ? 1 : 0);
      check_eq("sweep_strobe", {31'd0, sample_valid}, 1);
    end

    // rate_div=3: one strobe every 4th cycle
    rate_div = 8'd3;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (sample_valid) begin
        if (last >= 0) check_eq("rate_gap", i - last, 4);
        last = i;
      end
    end

    // saturation with full-scale noise
    do_reset(1);
    rate_div = 8'd0; noise_shift = 5'd0;
    hi_seen = 0; lo_seen = 0;
    for (int i = 0; i < 256; i++) begin
      run_cycle();
      if (i == 0) check_eq("sat_first", {16'd0, noisy}, 16'h2CE1);
      if (sample_valid && noisy == 16'hFFFF) hi_seen++;
      if (sample_valid && noisy == 16'h0000) lo_seen++;
    end
    check_eq("clamp_hi_seen", (hi_seen > 0) ? 1 : 0, 1);
    check_eq("clamp_lo_seen", (lo_seen > 0) ? 1 : 0, 1);

    // hold: freeze after sample 5, resume with SINE[5] plus the 6th noise word
    do_reset(1);
    noise_shift = 5'd3;
    repeat (5) run_cycle();
    enable = 1'b0;
    exp_v = noisy;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      check_eq("hold_frozen", {16'd0, noisy}, exp_v);
      check_eq("hold_no_strobe", {31'd0, sample_valid}, 0);
    end
    enable = 1'b1;
    run_cycle();
    l = 'hACE1;
    repeat (5) l = lfsr_next(l);
    check_eq("hold_resume", {16'd0, noisy}, sat_ref(sine_ref[5] + noise_ref(l, 3)));
    check_eq("hold_resume_strobe", {31'd0, sample_valid}, 1);

    // reset mid-run at addr=17, cnt=2
    rate_div = 8'd3;
    guard = 0;
    while (!(m_addr == 17 && m_cnt == 2) && guard < 500) begin
      run_cycle();
      guard++;
    end
    check_eq("midrst_reached", (guard < 500) ? 1 : 0, 1);
    do_reset(1);
    check_eq("midrst_noisy", {16'd0, noisy}, 0);
    check_eq("midrst_valid", {31'd0, sample_valid}, 0);
    check_eq("midrst_wrap", {31'd0, wrap}, 0);
    rate_div = 8'd0; noise_shift = 5'd2;
    run_cycle();
    check_eq("midrst_first", {16'd0, noisy}, 16'h6B38);

    // lowering rate_div below cnt samples on the next enabled cycle
    rate_div = 8'd200; noise_shift = 5'd16;
    guard = 0;
    while (m_cnt != 150 && guard < 400) begin
      run_cycle();
      guard++;
    end
    check_eq("ratechg_reached", (guard < 400) ? 1 : 0, 1);
    rate_div = 8'd10;
    run_cycle();
    check_eq("ratechg_immediate", {31'd0, sample_valid}, 1);
    last = 0;
    for (int i = 1; i <= 34; i++) begin
      run_cycle();
      if (sample_valid) begin
        check_eq("ratechg_period", i - last, 11);
        last = i;
      end
    end

    // randomized operation
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      enable  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rate_div = 8'($urandom_range(0, 6));
      noise_shift = 5'($urandom_range(0, 31));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
